// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the run/step clock-enable controller.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    // Resetting the edge history high means a divider output already high at release is not a tick.
    localparam logic TICK_PREV_RST = 1'b1;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/clk_step_ctrl_debounce.sv
// Counter-based debouncer: output follows a synchronised input only after
// DEBOUNCE_CYCLES consecutive samples disagree with the current output.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/step controller turning the divided clock level into a one-cycle cpu_en.
// Define STEP_DEBOUNCE_EN to debounce the step button; otherwise it is only synchronised.
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick_src,
    input  logic             run_sw,
    input  logic             step_btn,
    output logic             cpu_en,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count
);
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] run_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   run_s;
    logic                   btn_s;
    logic                   btn_db;
    logic                   btn_prev;
    logic                   step_req;
    logic                   tick_prev;
    logic                   tick;
    logic                   en_next;
    state_t                 state;
    state_t                 next_state;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_sync <= '0;
            btn_sync <= '0;
        end else begin
            run_sync <= {run_sync[SYNC_STAGES-2:0], run_sw};
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], step_btn};
        end
    end

    assign run_s = run_sync[SYNC_STAGES-1];
    assign btn_s = btn_sync[SYNC_STAGES-1];

`ifdef STEP_DEBOUNCE_EN
    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk (clk),
        .rstn(rstn),
        .din (btn_s),
        .dout(btn_db)
    );
`else
    assign btn_db = btn_s;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            btn_prev  <= 1'b0;
            tick_prev <= TICK_PREV_RST;
        end else begin
            btn_prev  <= btn_db;
            tick_prev <= tick_src;
        end
    end

    assign step_req = btn_db & ~btn_prev;
    assign tick     = tick_src & ~tick_prev;

    // Run switch takes priority everywhere; a step press only matters from HALT.
    always_comb begin
        next_state = state;
        en_next    = 1'b0;
        case (state)
            HALT: begin
                if (run_s) begin
                    next_state = RUN;
                end else if (step_req) begin
                    next_state = STEP;
                end
            end
            RUN: begin
                if (!run_s) begin
                    next_state = HALT;
                end else begin
                    en_next = tick;
                end
            end
            STEP: begin
                if (run_s) begin
                    next_state = RUN;
                    en_next    = tick;
                end else if (tick) begin
                    next_state = HALT;
                    en_next    = 1'b1;
                end
            end
            default: next_state = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= HALT;
            cpu_en      <= 1'b0;
            running     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state   <= next_state;
            cpu_en  <= en_next;
            running <= (next_state == RUN);
            if (cpu_en) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl with a pulse scoreboard; works with or without STEP_DEBOUNCE_EN.
module tb_clk_step_ctrl;
    localparam int CW = 4;
    localparam int DB = 4;
`ifdef STEP_DEBOUNCE_EN
    localparam int OFFSET = DB;
`else
    localparam int OFFSET = 0;
`endif

    logic          clk;
    logic          rstn;
    logic          tick_src;
    logic          run_sw;
    logic          step_btn;
    logic          cpu_en;
    logic          running;
    logic [CW-1:0] cycle_count;

    logic [CW-1:0] sb[$];
    int            exp_count = 0;
    int            errors    = 0;
    int            checks    = 0;

    clk_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tick_src   (tick_src),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .cpu_en     (cpu_en),
        .running    (running),
        .cycle_count(cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit b, input bit t, input int cycles);
        run_sw   = r;
        step_btn = b;
        tick_src = t;
        repeat (cycles) @(negedge clk);
    endtask

    // Each period: 4 cycles low, then 4 high; a pulse is expected per rising edge when asked.
    task automatic run_periods(input int n, input bit expect_pulse);
        for (int i = 0; i < n; i++) begin
            tick_src = 1'b0;
            repeat (4) @(negedge clk);
            tick_src = 1'b1;
            if (expect_pulse) begin
                sb.push_back(CW'(exp_count));
                exp_count++;
            end
            repeat (4) @(negedge clk);
        end
    endtask

    // Every cpu_en pulse must have been predicted; count shows the pre-pulse value.
    initial begin
        logic [CW-1:0] want;
        forever begin
            @(negedge clk);
            if (cpu_en === 1'b1) begin
                checkOutput("pulse_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    want = sb.pop_front();
                    checkOutput("pulse_count", 32'(cycle_count), 32'(want));
                end
            end
        end
    end

    initial begin
        rstn = 1'b0;
        run_sw = 1'b1;
        step_btn = 1'b0;
        tick_src = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("reset_running", 32'(running), 32'd0);
        checkOutput("reset_count", 32'(cycle_count), 32'd0);

        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("run_latency_early", 32'(running), 32'd0);
        @(negedge clk);
        checkOutput("run_latency", 32'(running), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("no_tick_at_release", 32'(cycle_count), 32'd0);

        $display("[TB] free-run");
        tick_src = 1'b0;
        repeat (4) @(negedge clk);
        tick_src = 1'b1;
        sb.push_back(CW'(exp_count));
        exp_count++;
        @(negedge clk);
        checkOutput("pulse_at_n_plus_1", 32'(cpu_en), 32'd1);
        @(negedge clk);
        checkOutput("pulse_one_cycle", 32'(cpu_en), 32'd0);
        repeat (2) @(negedge clk);
        run_periods(9, 1'b1);
        checkOutput("freerun_count", 32'(cycle_count), 32'd10);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        checkOutput("halt_after_run", 32'(running), 32'd0);
        checkOutput("freerun_drained", 32'(sb.size()), 32'd0);

        $display("[TB] single step");
        applyStimulus(1'b0, 1'b1, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        run_periods(1, 1'b1);
        run_periods(1, 1'b0);
        checkOutput("step_count", 32'(cycle_count), 32'd11);
        checkOutput("step_halted", 32'(running), 32'd0);

        $display("[TB] bouncy press");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2);
            applyStimulus(1'b0, 1'b0, 1'b0, 2);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        run_periods(1, 1'b1);
        run_periods(1, 1'b0);
        checkOutput("bouncy_count", 32'(cycle_count), 32'd12);

        $display("[TB] run over step");
        applyStimulus(1'b0, 1'b1, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        checkOutput("step_to_run", 32'(running), 32'd1);
        run_periods(1, 1'b1);
        checkOutput("run_over_step_count", 32'(cycle_count), 32'd13);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        checkOutput("halt_again", 32'(running), 32'd0);

        $display("[TB] simultaneous run and step");
        applyStimulus(1'b0, 1'b1, 1'b0, OFFSET);
        applyStimulus(1'b1, 1'b1, 1'b0, 2);
        checkOutput("coincide_not_yet", 32'(running), 32'd0);
        @(negedge clk);
        checkOutput("run_wins", 32'(running), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        run_periods(2, 1'b1);
        checkOutput("coincide_count", 32'(cycle_count), 32'd15);

        $display("[TB] wrap");
        tick_src = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_count = 0;
        checkOutput("rerun_reset_count", 32'(cycle_count), 32'd0);
        repeat (3) @(negedge clk);
        run_periods(17, 1'b1);
        checkOutput("wrap_count", 32'(cycle_count), 32'd1);

        $display("[TB] mid-run reset");
        tick_src = 1'b0;
        repeat (4) @(negedge clk);
        tick_src = 1'b1;
        sb.push_back(CW'(exp_count));
        exp_count++;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_count = 0;
        checkOutput("midreset_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("midreset_running", 32'(running), 32'd0);
        checkOutput("midreset_count", 32'(cycle_count), 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("post_reset_running", 32'(running), 32'd1);
        checkOutput("post_reset_no_pulse", 32'(cycle_count), 32'd0);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
